alu_seq: RTL

- Parametrised, registered successor to the single-cycle 16-bit datapath ALU.
- Same 3-bit op encoding, generalised to WIDTH bits.
- Adds carry/overflow flags, a start/busy/done handshake, and an iterative shift-add multiplier so no WIDTH x WIDTH array multiplier sits on the CPU critical path.
- Sits in the execute stage; the control unit stalls the PC while busy is high.

---
 rtl/alu_seq.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with start/busy/done handshake.
// Single-cycle ops register their result at the accept edge; op 111 runs an
// iterative shift-add multiplier for WIDTH cycles.
// Optional feature macro: ALU_SEQ_MULHI_EN adds output y_hi (upper product half).
module alu_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op_alu,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             sign,
    output logic             carry,
    output logic             overflow,
    output logic             busy,
`ifdef ALU_SEQ_MULHI_EN
    output logic [WIDTH-1:0] y_hi,
`endif
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_NOT  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_NEG  = 3'b110,
        OP_MUL  = 3'b111
    } op_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               zero_q, zero_d;
    logic               sign_q, sign_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
`ifdef ALU_SEQ_MULHI_EN
    logic [WIDTH-1:0]   hi_q, hi_d;
`endif

    logic               accept;
    op_t                op;
    logic [WIDTH:0]     sum_ext, diff_ext;
    logic [WIDTH-1:0]   neg_res;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;
    logic [2*WIDTH-1:0] prod;

    assign op     = op_t'(op_alu);
    assign accept = start && (state_q == S_IDLE);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: leave IDLE only for a multiply, return after the last iteration
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && op == OP_MUL) state_d = S_MUL;
            S_MUL:  if (cnt_q == LAST)          state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle ALU result and flags for the non-multiply ops
    always_comb begin
        sum_ext  = {1'b0, a} + {1'b0, b};
        diff_ext = {1'b0, a} - {1'b0, b};
        neg_res  = '0 - a;
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op)
            OP_PASS: alu_res = a;
            OP_NOT:  alu_res = ~a;
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NEG: begin
                alu_res = neg_res;
                alu_c   = |a;
                // 0 - a overflows only when a is the most negative value
                alu_v   = a[WIDTH-1] & neg_res[WIDTH-1];
            end
            default: ;
        endcase
    end

    // Datapath next-state: accept/launch in IDLE, one shift-add step per MUL cycle
    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        y_d      = y_q;
        zero_d   = zero_q;
        sign_d   = sign_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
`ifdef ALU_SEQ_MULHI_EN
        hi_d     = hi_q;
`endif
        prod     = acc_q + (mplier_q[0] ? mcand_q : '0);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        y_d     = alu_res;
                        zero_d  = (alu_res == '0);
                        sign_d  = alu_res[WIDTH-1];
                        carry_d = alu_c;
                        ovf_d   = alu_v;
                        done_d  = 1'b1;
`ifdef ALU_SEQ_MULHI_EN
                        hi_d    = '0;
`endif
                    end
                end
            end
            S_MUL: begin
                acc_d    = prod;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // The final step writes straight from the freshly summed product
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    y_d     = prod[WIDTH-1:0];
                    zero_d  = (prod[WIDTH-1:0] == '0);
                    sign_d  = prod[WIDTH-1];
                    carry_d = 1'b0;
                    ovf_d   = |prod[2*WIDTH-1:WIDTH];
                    done_d  = 1'b1;
`ifdef ALU_SEQ_MULHI_EN
                    hi_d    = prod[2*WIDTH-1:WIDTH];
`endif
                end
            end
            default: ;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            y_q      <= '0;
            zero_q   <= 1'b1;
            sign_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_SEQ_MULHI_EN
            hi_q     <= '0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            y_q      <= y_d;
            zero_q   <= zero_d;
            sign_q   <= sign_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
`ifdef ALU_SEQ_MULHI_EN
            hi_q     <= hi_d;
`endif
        end
    end

    // Outputs
    always_comb begin
        busy     = (state_q == S_MUL);
        y        = y_q;
        zero     = zero_q;
        sign     = sign_q;
        carry    = carry_q;
        overflow = ovf_q;
        done     = done_q;
`ifdef ALU_SEQ_MULHI_EN
        y_hi     = hi_q;
`endif
    end

endmodule
